stepmotor_monitor: RTL and testbench



---
 rtl/stepmotor_monitor.sv | 185 ++++++++++++++++++
 tb/tb_stepmotor_monitor.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/stepmotor_monitor.sv
// Stepper coil monitor: synchronises and debounces the L1L2L3L4 pattern, decodes
// full-step phases into step/direction/position, measures step period and flags faults.
module stepmotor_monitor #(
    parameter int unsigned POS_W   = 16,
    parameter int unsigned PER_W   = 16,
    parameter int unsigned FILT    = 2,
    parameter int unsigned TIMEOUT = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [3:0]       coils,
    output logic             step,
    output logic             dir,
    output logic [POS_W-1:0] pos,
    output logic [PER_W-1:0] period,
    output logic [1:0]       phase,
    output logic             locked,
    output logic             moving,
    output logic [1:0]       err
);

    // Stability counter runs 0..FILT+1; FILT+1 marks "already accepted".
    localparam int unsigned CNT_W = $clog2(FILT + 2);

    logic [3:0]       s1_q, s2_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             step_q, step_d;
    logic             dir_q, dir_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic [PER_W-1:0] period_q, period_d;
    logic [PER_W-1:0] pc_q, pc_d, pc_inc;
    logic [1:0]       phase_q, phase_d;
    logic             locked_q, locked_d;
    logic             moving_q, moving_d;
    logic [1:0]       err_q, err_d;
    logic             first_q, first_d;

    logic             accept_c;
    logic             valid_c;
    logic [1:0]       idx_c;
    logic [1:0]       diff_c;

    // Two-flop synchroniser on the asynchronous coil pattern.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= 4'b0000;
            s2_q <= 4'b0000;
        end else begin
            s1_q <= coils;
            s2_q <= s1_q;
        end
    end

    // Debounce: restart when the synchronised value is about to change, accept once at FILT.
    always_comb begin
        cnt_d = cnt_q;
        if (s1_q != s2_q) begin
            cnt_d = CNT_W'(1);
        end else if (cnt_q <= CNT_W'(FILT)) begin
            cnt_d = CNT_W'(cnt_q + CNT_W'(1));
        end
    end

    assign accept_c = (cnt_q == CNT_W'(FILT));

    // Phase decode of the two-phase-on full-step sequence.
    always_comb begin
        valid_c = 1'b1;
        idx_c   = 2'd0;
        case (s2_q)
            4'b1001: idx_c = 2'd0;
            4'b0011: idx_c = 2'd1;
            4'b0110: idx_c = 2'd2;
            4'b1100: idx_c = 2'd3;
            default: valid_c = 1'b0;
        endcase
    end

    assign diff_c = idx_c - phase_q;
    assign pc_inc = (pc_q == {PER_W{1'b1}}) ? pc_q : PER_W'(pc_q + PER_W'(1));

    // Next-state: acceptance rules, period measurement, motion timeout and clear.
    always_comb begin
        step_d   = 1'b0;
        dir_d    = dir_q;
        pos_d    = pos_q;
        period_d = period_q;
        phase_d  = phase_q;
        locked_d = locked_q;
        moving_d = moving_q;
        err_d    = err_q;
        first_d  = first_q;
        pc_d     = pc_inc;

        if (accept_c) begin
            if (s2_q == 4'b0000) begin
                locked_d = 1'b0;
            end else if (!valid_c) begin
                err_d[1] = 1'b1;
                locked_d = 1'b0;
            end else if (!locked_q) begin
                phase_d  = idx_c;
                locked_d = 1'b1;
                first_d  = 1'b1;
            end else begin
                phase_d = idx_c;
                case (diff_c)
                    2'd1: begin
                        step_d = 1'b1;
                        dir_d  = 1'b0;
                        pos_d  = POS_W'(pos_q + POS_W'(1));
                    end
                    2'd3: begin
                        step_d = 1'b1;
                        dir_d  = 1'b1;
                        pos_d  = POS_W'(pos_q - POS_W'(1));
                    end
                    2'd2:    err_d[0] = 1'b1;
                    default: ;
                endcase
            end
        end

        if (step_d) begin
            // Interval before the first step after locking is unknown.
            period_d = first_q ? '0 : pc_inc;
            pc_d     = '0;
            first_d  = 1'b0;
            moving_d = 1'b1;
        end else if (pc_q >= PER_W'(TIMEOUT)) begin
            moving_d = 1'b0;
        end

        if (locked_q && !locked_d) begin
            moving_d = 1'b0;
        end

        if (clr) begin
            pos_d    = '0;
            period_d = '0;
            err_d    = 2'b00;
            pc_d     = '0;
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            step_q   <= 1'b0;
            dir_q    <= 1'b0;
            pos_q    <= '0;
            period_q <= '0;
            pc_q     <= '0;
            phase_q  <= 2'd0;
            locked_q <= 1'b0;
            moving_q <= 1'b0;
            err_q    <= 2'b00;
            first_q  <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            step_q   <= step_d;
            dir_q    <= dir_d;
            pos_q    <= pos_d;
            period_q <= period_d;
            pc_q     <= pc_d;
            phase_q  <= phase_d;
            locked_q <= locked_d;
            moving_q <= moving_d;
            err_q    <= err_d;
            first_q  <= first_d;
        end
    end

    assign step   = step_q;
    assign dir    = dir_q;
    assign pos    = pos_q;
    assign period = period_q;
    assign phase  = phase_q;
    assign locked = locked_q;
    assign moving = moving_q;
    assign err    = err_q;

endmodule

// File: tb/tb_stepmotor_monitor.sv
// Directed bench for stepmotor_monitor; narrow position/period widths keep wrap and saturation short.
module tb_stepmotor_monitor;

    localparam int unsigned POS_W   = 8;
    localparam int unsigned PER_W   = 8;
    localparam int unsigned FILT    = 2;
    localparam int unsigned TIMEOUT = 100;

    logic             clk = 1'b0;
    logic             rst;
    logic             clr;
    logic [3:0]       coils;
    logic             step;
    logic             dir;
    logic [POS_W-1:0] pos;
    logic [PER_W-1:0] period;
    logic [1:0]       phase;
    logic             locked;
    logic             moving;
    logic [1:0]       err;

    int total = 0;
    int bad   = 0;
    int steps_seen = 0;
    int base;
    int ph;
    logic [3:0] pats [4];

    stepmotor_monitor #(
        .POS_W(POS_W), .PER_W(PER_W), .FILT(FILT), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .clr(clr), .coils(coils),
        .step(step), .dir(dir), .pos(pos), .period(period),
        .phase(phase), .locked(locked), .moving(moving), .err(err)
    );

    always #5 clk = ~clk;

    // Running count of step pulses.
    always @(negedge clk) if (step) steps_seen++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apply(input int idx, input int n);
        coils = pats[idx];
        tick(n);
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
    endtask

    initial begin
        pats[0] = 4'b1001; pats[1] = 4'b0011; pats[2] = 4'b0110; pats[3] = 4'b1100;
        rst = 1'b1; clr = 1'b0; coils = 4'b0000;
        tick(3);
        chk("rst_step", 32'(step), 32'd0);
        chk("rst_dir", 32'(dir), 32'd0);
        chk("rst_pos", 32'(pos), 32'd0);
        chk("rst_period", 32'(period), 32'd0);
        chk("rst_phase", 32'(phase), 32'd0);
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_moving", 32'(moving), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rst = 1'b0;
        tick(2);

        // Lock on first valid pattern after 2+FILT cycles.
        coils = 4'b1001;
        tick(3);
        chk("lock_early", 32'(locked), 32'd0);
        tick(1);
        chk("lock_locked", 32'(locked), 32'd1);
        chk("lock_phase", 32'(phase), 32'd0);
        chk("lock_step", 32'(step), 32'd0);
        chk("lock_pos", 32'(pos), 32'd0);
        tick(6);

        // Forward sequence, 50 cycles per phase.
        base = steps_seen;
        apply(1, 50); apply(2, 50); apply(3, 50); apply(0, 50);
        chk("fwd_count", 32'(steps_seen - base), 32'd4);
        chk("fwd_dir", 32'(dir), 32'd0);
        chk("fwd_pos", 32'(pos), 32'd4);
        chk("fwd_period", 32'(period), 32'd50);
        chk("fwd_moving", 32'(moving), 32'd1);
        chk("fwd_phase", 32'(phase), 32'd0);

        // Clear, then reverse two steps.
        pulse_clr();
        chk("clr_pos", 32'(pos), 32'd0);
        chk("clr_period", 32'(period), 32'd0);
        base = steps_seen;
        apply(3, 50); apply(2, 50);
        chk("rev_count", 32'(steps_seen - base), 32'd2);
        chk("rev_dir", 32'(dir), 32'd1);
        chk("rev_pos", 32'(pos), 32'hFE);
        chk("rev_phase", 32'(phase), 32'd2);

        // Skipped phase (2 -> 0), then illegal pattern, then clear.
        base = steps_seen;
        apply(0, 20);
        chk("skip_err", 32'(err), 32'b01);
        chk("skip_count", 32'(steps_seen - base), 32'd0);
        chk("skip_pos", 32'(pos), 32'hFE);
        chk("skip_phase", 32'(phase), 32'd0);
        coils = 4'b1010;
        tick(20);
        chk("ill_err", 32'(err), 32'b11);
        chk("ill_locked", 32'(locked), 32'd0);
        chk("ill_moving", 32'(moving), 32'd0);
        pulse_clr();
        chk("clr2_err", 32'(err), 32'd0);
        chk("clr2_pos", 32'(pos), 32'd0);

        // Relock, then a one-cycle glitch must be ignored.
        apply(0, 10);
        chk("relock", 32'(locked), 32'd1);
        base = steps_seen;
        coils = 4'b0011;
        tick(1);
        coils = 4'b1001;
        tick(20);
        chk("glitch_count", 32'(steps_seen - base), 32'd0);
        chk("glitch_phase", 32'(phase), 32'd0);

        // Timeout and period saturation.
        apply(1, 54);
        chk("to_count", 32'(steps_seen - base), 32'd1);
        chk("to_first_period", 32'(period), 32'd0);
        chk("to_moving_on", 32'(moving), 32'd1);
        tick(100);
        chk("to_moving_off", 32'(moving), 32'd0);
        tick(200);
        apply(2, 5);
        chk("sat_period", 32'(period), 32'hFF);
        chk("sat_moving", 32'(moving), 32'd1);
        chk("sat_pos", 32'(pos), 32'd2);

        // Position wrap 7F -> 80 -> 81.
        pulse_clr();
        ph = 2;
        for (int k = 0; k < 127; k++) begin
            ph = (ph + 1) % 4;
            apply(ph, 4);
        end
        chk("wrap_7f", 32'(pos), 32'h7F);
        ph = (ph + 1) % 4; apply(ph, 4);
        chk("wrap_80", 32'(pos), 32'h80);
        ph = (ph + 1) % 4; apply(ph, 4);
        chk("wrap_81", 32'(pos), 32'h81);

        // Clear coincident with a step: pulse and dir still happen, pos/period zeroed.
        ph = (ph + 1) % 4;
        coils = pats[ph];
        tick(3);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        chk("clrstep_step", 32'(step), 32'd1);
        chk("clrstep_pos", 32'(pos), 32'd0);
        chk("clrstep_period", 32'(period), 32'd0);
        chk("clrstep_dir", 32'(dir), 32'd0);
        tick(2);
        chk("clrstep_done", 32'(step), 32'd0);

        // Reset mid-sequence: next valid pattern only relocks.
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("mid_rst_locked", 32'(locked), 32'd0);
        base = steps_seen;
        apply((ph + 1) % 4, 10);
        chk("mid_rst_relock", 32'(locked), 32'd1);
        chk("mid_rst_nostep", 32'(steps_seen - base), 32'd0);
        chk("mid_rst_pos", 32'(pos), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
